// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the configuration bitstream loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHK,
    ST_COMMIT
  } cfg_state_e;

  localparam logic [7:0] CFG_SYNC_DEFAULT = 8'hA5;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A single-word frame still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CFG_NWORDS_DEFAULT = ceil_div(248, 8);
  localparam int CFG_CNT_W_DEFAULT  = cnt_width(CFG_NWORDS_DEFAULT);

endpackage

// File: rtl/cfg_checksum.sv
// XOR accumulator over the payload words of one frame.
// Used only when CFG_LOADER_CHECKSUM_EN is defined.
module cfg_checksum #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc,
  input  logic [WORD_W-1:0] data,
  output logic              match
);

  logic [WORD_W-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc) begin
      sum <= sum ^ data;
    end
  end

  assign match = (sum == data);

endmodule

// File: rtl/cfg_loader.sv
// Byte-serial configuration loader with atomic commit into the tile switch vector.
// Define CFG_LOADER_CHECKSUM_EN to add the trailing checksum word and cfg_err.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for SYNC, other words dropped
//   ST_LOAD   | filling shadow register, one word per transfer
//   ST_CHK    | waiting for checksum word (checksum build only)
//   ST_COMMIT | one cycle, in_ready low, shadow copied to cfg_out
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int                CFG_BITS = 248,
  parameter int                WORD_W   = 8,
  parameter logic [WORD_W-1:0] SYNC     = WORD_W'(CFG_SYNC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                cfg_abort,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_done,
  output logic                cfg_busy,
  output logic                cfg_err
);

  localparam int                NWORDS   = ceil_div(CFG_BITS, WORD_W);
  localparam int                CNT_W    = cnt_width(NWORDS);
  localparam int                SHADOW_W = NWORDS * WORD_W;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(NWORDS - 1);

  cfg_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SHADOW_W-1:0] shadow;
  logic                xfer;
  logic                sync_hit;
  logic                load_we;
  logic                commit_en;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic                chk_match;
  logic                chk_fail;
`endif

  assign in_ready = !cfg_abort && (state != ST_COMMIT);
  assign xfer     = in_valid && in_ready;
  assign cfg_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sync_hit  = 1'b0;
    load_we   = 1'b0;
    commit_en = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    chk_fail  = 1'b0;
`endif
    if (cfg_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer && (in_data == SYNC)) begin
            sync_hit  = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            load_we = 1'b1;
            if (cnt == LAST) begin
`ifdef CFG_LOADER_CHECKSUM_EN
              state_nxt = ST_CHK;
`else
              state_nxt = ST_COMMIT;
`endif
            end
          end
        end
        ST_CHK: begin
`ifdef CFG_LOADER_CHECKSUM_EN
          if (xfer) begin
            if (chk_match) begin
              state_nxt = ST_COMMIT;
            end else begin
              chk_fail  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
        ST_COMMIT: begin
          commit_en = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_hit || cfg_abort) begin
      cnt <= '0;
    end else if (load_we) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Each payload word lands in its own slice; pad bits above CFG_BITS are never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (sync_hit) begin
      shadow <= '0;
    end else if (load_we) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (cnt == CNT_W'(k)) begin
          shadow[k*WORD_W +: WORD_W] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out  <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= commit_en;
      if (commit_en) begin
        cfg_out <= shadow[CFG_BITS-1:0];
      end
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  cfg_checksum #(
    .WORD_W (WORD_W)
  ) u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sync_hit),
    .acc   (load_we),
    .data  (in_data),
    .match (chk_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (sync_hit) begin
      cfg_err <= 1'b0;
    end else if (chk_fail) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: frame-level reference model plus directed frames.
`timescale 1ns/1ps
module tb_cfg_loader;
  import cfg_pkg::*;

  localparam int         CB = 248;
  localparam int         WW = 8;
  localparam int         NW = ceil_div(CB, WW);
  localparam logic [7:0] SY = 8'hA5;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, cfg_done, cfg_busy, cfg_err;
  logic [CB-1:0] cfg_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  cfg_loader #(.CFG_BITS(CB), .WORD_W(WW), .SYNC(SY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_abort (cfg_abort),
    .cfg_out   (cfg_out),
    .cfg_done  (cfg_done),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the list of payload words after SYNC.
  logic [7:0]    m_q[$];
  logic [CB-1:0] m_out = '0;
  bit            m_frame = 1'b0, m_commit = 1'b0, m_done = 1'b0, m_err = 1'b0;

  function automatic logic [CB-1:0] pack_words();
    logic [NW*WW-1:0] t = '0;
    for (int i = 0; i < m_q.size(); i++) t[i*WW +: WW] = m_q[i];
    return t[CB-1:0];
  endfunction

  function automatic logic [7:0] xor_words();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x = x ^ m_q[i];
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= '0; m_done <= 1'b0; m_err <= 1'b0; m_frame <= 1'b0; m_commit <= 1'b0;
      m_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_commit) begin
        if (!cfg_abort) begin
          m_out  <= pack_words();
          m_done <= 1'b1;
        end
        m_commit <= 1'b0;
        m_frame  <= 1'b0;
        m_q.delete();
      end else if (cfg_abort) begin
        m_frame <= 1'b0;
        m_q.delete();
      end else if (in_valid) begin
        if (!m_frame) begin
          if (in_data == SY) begin
            m_frame <= 1'b1;
            m_err   <= 1'b0;
          end
        end else if (m_q.size() < NW) begin
          m_q.push_back(in_data);
          if (m_q.size() == NW && !CHK_ON) m_commit <= 1'b1;
        end else if (in_data == xor_words()) begin
          m_commit <= 1'b1;
        end else begin
          m_err   <= 1'b1;
          m_frame <= 1'b0;
          m_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready", in_ready, !m_commit && !cfg_abort);
      check("cfg_busy", cfg_busy, m_frame);
      check("cfg_done", cfg_done, m_done);
      check("cfg_err",  cfg_err,  m_err);
      check("cfg_out",  cfg_out,  m_out);
    end
  end

  logic [7:0] fw [NW];

  task automatic drive(input logic v, input logic [7:0] d, input logic ab);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    cfg_abort = ab;
  endtask

  task automatic send_frame(input bit gaps, input logic [7:0] chk_flip);
    logic [7:0] x = 8'h00;
    drive(1'b1, SY, 1'b0);
    for (int i = 0; i < NW; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) drive(1'b0, 8'h3C, 1'b0);
      drive(1'b1, fw[i], 1'b0);
      x = x ^ fw[i];
    end
    if (CHK_ON) drive(1'b1, x ^ chk_flip, 1'b0);
  endtask

  // Last word was accepted at edge T; pins the T+1 / T+2 timing by hand.
  task automatic finish_commit(input string tag);
    drive(1'b0, 8'h00, 1'b0); #2;
    check({tag, "_commit_ready"}, in_ready, 1'b0);
    check({tag, "_commit_done"},  cfg_done, 1'b0);
    check({tag, "_commit_busy"},  cfg_busy, 1'b1);
    drive(1'b0, 8'h00, 1'b0); #2;
    check({tag, "_done_pulse"},   cfg_done, 1'b1);
    check({tag, "_ready_back"},   in_ready, 1'b1);
    check({tag, "_idle_busy"},    cfg_busy, 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check({tag, "_done_fall"},    cfg_done, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CB-1:0] exp_v;
    #1 rst_n = 1'b0;
    #3;
    check("rst_out",   cfg_out,  '0);
    check("rst_busy",  cfg_busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_done",  cfg_done, 1'b0);
    check("rst_err",   cfg_err,  1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // leading garbage, then gap-free frame 0x00..0x1E
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("garbage_busy", cfg_busy, 1'b0);
    for (int i = 0; i < NW; i++) fw[i] = 8'(i);
    send_frame(1'b0, 8'h00);
    finish_commit("seq");
    check("seq_lsb",   cfg_out[7:0],     8'h00);
    check("seq_w1",    cfg_out[15:8],    8'h01);
    check("seq_msb",   cfg_out[247:240], 8'h1E);
    check("model_msb", m_out[247:240],   8'h1E);

    // reset mid-LOAD after 10 words, then a full frame containing SYNC as data
    for (int i = 0; i < NW; i++) fw[i] = 8'(i * 7 + 3);
    fw[5] = SY;
    drive(1'b1, SY, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, fw[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("midrst_out",   cfg_out,  '0);
    check("midrst_busy",  cfg_busy, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b0, 8'h00);
    finish_commit("rstfr");
    check("rstfr_w0",   cfg_out[7:0],   8'h03);
    check("rstfr_w1",   cfg_out[15:8],  8'h0A);
    check("rstfr_sync", cfg_out[47:40], SY);

    // abort together with payload word 15
    drive(1'b1, SY, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b1, fw[i], 1'b0);
    drive(1'b1, fw[15], 1'b1); #2;
    check("abort_ready", in_ready, 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("abort_busy", cfg_busy, 1'b0);
    check("abort_out",  cfg_out[7:0], 8'h03);
    for (int i = 16; i < NW; i++) drive(1'b1, fw[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("abort_tail_busy", cfg_busy, 1'b0);

    // random valid gaps; result must equal the gap-free 0x00..0x1E image
    for (int i = 0; i < NW; i++) fw[i] = 8'(i);
    send_frame(1'b1, 8'h00);
    finish_commit("gap");
    exp_v = '0;
    for (int i = 0; i < NW; i++) exp_v[i*8 +: 8] = 8'(i);
    check("gap_image", cfg_out, exp_v);

    // abort during the COMMIT cycle cancels the commit
    for (int i = 0; i < NW; i++) fw[i] = 8'hFF - 8'(i);
    send_frame(1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b1); #2;
    check("cabort_ready", in_ready, 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("cabort_done", cfg_done, 1'b0);
    check("cabort_out",  cfg_out, exp_v);

`ifdef CFG_LOADER_CHECKSUM_EN
    for (int i = 0; i < NW; i++) fw[i] = 8'(i) ^ 8'h55;
    send_frame(1'b0, 8'h00);
    finish_commit("ck_good");
    check("ck_good_w0", cfg_out[7:0], 8'h55);
    for (int i = 0; i < NW; i++) fw[i] = 8'(i + 1);
    send_frame(1'b0, 8'h01);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("ck_bad_err",  cfg_err,  1'b1);
    check("ck_bad_busy", cfg_busy, 1'b0);
    check("ck_bad_done", cfg_done, 1'b0);
    drive(1'b0, 8'h00, 1'b0); #2;
    check("ck_bad_done2", cfg_done, 1'b0);
    check("ck_bad_out",   cfg_out[7:0], 8'h55);
    send_frame(1'b0, 8'h00);
    finish_commit("ck_next");
    check("ck_next_err", cfg_err, 1'b0);
    check("ck_next_w0",  cfg_out[7:0], 8'h01);
`endif

    repeat (3) drive(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Configuration bitstream loader for one routing tile. Accepts a byte-serial configuration stream over a valid/ready handshake, assembles it into a shadow register, and commits it atomically to the `CFG_BITS`-wide switch-control vector that drives the tile's connection-block `c` input. The fabric never sees a partially loaded configuration.

## Interface
- `CFG_BITS`, 248, width of the committed configuration vector. The default matches a connection block with default parameters.
- `WORD_W`, 8, stream word width.
- `SYNC`, 8'hA5, sync word that opens a frame.
- `clk` input 1: the only clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_data` input `WORD_W`: stream word.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the loader can accept a word this cycle.
- `cfg_abort` input 1: synchronous abort of the frame in progress.
- `cfg_out` output `CFG_BITS`: committed switch controls; bit k drives `c[k]`.
- `cfg_done` output 1: one-cycle pulse when a commit takes effect.
- `cfg_busy` output 1: a frame is in progress (state is not IDLE).
- `cfg_err` output 1: sticky checksum error. Tied to 0 when checksum support is compiled out.

## Operation
- `NWORDS` = ceil(`CFG_BITS`/`WORD_W`) = 31 by default.
- A word transfers on a rising `clk` edge where `in_valid` and `in_ready` are both 1.
- States:
  - IDLE: `in_ready`=1. Non-SYNC words are accepted and discarded. A SYNC word clears the shadow register, clears the word counter, clears `cfg_err`, and moves to LOAD.
  - LOAD: `in_ready`=1. Payload word k is written to shadow bits [k*`WORD_W` +: `WORD_W`], LSB-first. Bits at index ≥`CFG_BITS` are dropped. The counter wraps at `NWORDS`. After word `NWORDS`-1 the FSM moves to CHK (macro defined) or COMMIT (macro undefined).
  - CHK: `in_ready`=1. Accepts one checksum word. On match, moves to COMMIT. On mismatch, sets `cfg_err`=1 and returns to IDLE; the shadow register is discarded and `cfg_out` is unchanged.
  - COMMIT: `in_ready`=0 for exactly one cycle. `cfg_out` is loaded from the shadow register, `cfg_done` is set for the next cycle, and the FSM returns to IDLE.
- A SYNC value received in LOAD or CHK is treated as data. There is no resync mid-frame.
- `cfg_abort`=1 forces `in_ready`=0 in that cycle, so abort wins over a simultaneous valid word. The FSM goes to IDLE; shadow and counter are discarded; `cfg_out` and `cfg_err` are unchanged. Abort during COMMIT also wins, and the commit does not occur.
- Reset values: `cfg_out`=0 (all switches open), `cfg_done`=0, `cfg_busy`=0, `cfg_err`=0, `in_ready`=1 (state IDLE). Reset mid-frame loses all partial data.

## Timing
- Word-per-cycle throughput in IDLE, LOAD and CHK.
- Final word (payload or checksum) accepted at edge T: COMMIT runs during cycle T..T+1. New `cfg_out` is visible and `cfg_done`=1 from edge T+1. `cfg_done` falls at T+2, and `in_ready` returns to 1 at T+1.
- Minimum frame spacing is 1 + `NWORDS` (+1 with checksum) + 1 cycles.
- `cfg_out` changes only at the end of a COMMIT cycle; it is otherwise fully registered and glitch-free.
- `cfg_err` is set at the edge following the mismatching word.

## Configuration
- `CFG_LOADER_CHECKSUM_EN` defined:
  - The CHK state exists.
  - Checksum = XOR of all `NWORDS` payload words as received, including dropped pad bits.
  - `cfg_err` is functional.
- Undefined:
  - LOAD goes directly to COMMIT.
  - `cfg_err` is constant 0.
  - No checksum logic is built.

## Structure
- Package `cfg_pkg`:
  - state enum (IDLE, LOAD, CHK, COMMIT);
  - `SYNC` default;
  - `ceil_div` function for `NWORDS`;
  - counter width = $clog2(`NWORDS`).
- Sub-module `cfg_checksum`: XOR accumulator with clear, accumulate and compare. Instantiated only under `CFG_LOADER_CHECKSUM_EN`.

## Test plan
- Reset mid-LOAD after 10 words: `cfg_out`=0, `cfg_busy`=0, `in_ready`=1, and a following full frame commits correctly.
- Frame SYNC followed by 31 words 8'h00..8'h1E, with no gaps (macro off): `cfg_done` pulses at T+1 and `cfg_out[7:0]`=8'h00. `cfg_out[247:240]`=8'h1E, since word 30 lands in bits [247:240] (with `CFG_BITS`=248 no bits are dropped).
- Leading garbage 8'h00, 8'h5A before SYNC: both are discarded, `cfg_busy` stays 0 until SYNC is accepted, and the frame loads normally.
- Macro on, correct checksum (XOR of payload) sent: commit occurs. Checksum XOR 8'h01 sent: `cfg_err`=1, no `cfg_done`, `cfg_out` keeps its previous frame. The next good frame clears `cfg_err`.
- `cfg_abort` asserted together with `in_valid` on payload word 15: the word is not accepted (`in_ready`=0), state goes to IDLE, and `cfg_out` is unchanged.
- Random `in_valid` gaps (50% duty) during a frame: the committed `cfg_out` is identical to the gap-free run, and `in_ready` is 0 only during the COMMIT or abort cycle.
